// File: rtl/function_sweep_ctrl.sv
// ============================================================================
// function_sweep_ctrl
// ----------------------------------------------------------------------------
// Sequencer for the 5-input combinational function datapath. When a sweep is
// accepted, it walks the operand vector {a,b,c,d,e} from i_first_vec to
// i_last_vec. For each vector it waits SETTLE_CYC cycles, then samples i_f_in.
// The sampled values build a truth-table map and a count of ones.
//
// Optional feature (compile-time macro FUNC_SWEEP_ABORT_EN):
//   adds input i_abort. Asserting it in SETTLE or SAMPLE ends the sweep with an
//   err pulse and no done pulse. Partial results are kept.
//
// Parameters
//   VEC_W       operand vector width (1..5); o_tt_out is 2**VEC_W bits wide
//   SETTLE_CYC  wait cycles per vector before f is sampled (0 allowed)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      sweep request, looked at only in IDLE
//   i_first_vec  first vector of the range, latched on accept
//   i_last_vec   last vector of the range (inclusive), latched on accept
//   i_abort      (FUNC_SWEEP_ABORT_EN only) abort the running sweep
//   i_f_in       datapath output f for the current o_vec_out
//   o_vec_out    registered {a,b,c,d,e} to the datapath, a = MSB
//   o_busy       high from the accept until the sweep completes
//   o_done       one-cycle pulse when the sweep completes
//   o_err        one-cycle pulse when a range is rejected or a sweep is aborted
//   o_tt_out     bit k = sampled f for vector k; bits that were not swept = 0
//   o_ones_cnt   number of sampled f==1 in the current sweep
// ============================================================================
module function_sweep_ctrl #(
  parameter int unsigned VEC_W      = 5,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [VEC_W-1:0]        i_first_vec,
  input  logic [VEC_W-1:0]        i_last_vec,
`ifdef FUNC_SWEEP_ABORT_EN
  input  logic                    i_abort,
`endif
  input  logic                    i_f_in,
  output logic [VEC_W-1:0]        o_vec_out,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [(2**VEC_W)-1:0]   o_tt_out,
  output logic [VEC_W:0]          o_ones_cnt
);

  localparam int unsigned TT_W  = 2**VEC_W;
  localparam int unsigned CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // First state after a vector is driven: skip SETTLE entirely when no wait is asked for.
  localparam state_t VEC_ENTRY = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  state_t             r_state, w_state_nxt;
  logic [VEC_W-1:0]   r_vec,   w_vec_nxt;
  logic [VEC_W-1:0]   r_last,  w_last_nxt;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [TT_W-1:0]    r_tt,    w_tt_nxt;
  logic [VEC_W:0]     r_ones,  w_ones_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;
  logic               r_err,   w_err_nxt;
  logic               w_abort;

`ifdef FUNC_SWEEP_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_tt    <= '0;
      r_ones  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tt    <= w_tt_nxt;
      r_ones  <= w_ones_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // done/busy/err are registered, so they change one edge after the state that
  // causes them. done therefore appears the cycle after DONE, together with busy
  // dropping.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_tt_nxt    = r_tt;
    w_ones_nxt  = r_ones;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_first_vec <= i_last_vec) begin
            w_last_nxt  = i_last_vec;
            w_vec_nxt   = i_first_vec;
            w_tt_nxt    = '0;
            w_ones_nxt  = '0;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = VEC_ENTRY;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_tt_nxt[r_vec] = i_f_in;
          w_ones_nxt      = r_ones + {{VEC_W{1'b0}}, i_f_in};
          if (r_vec == r_last) begin
            w_state_nxt = DONE;
          end else begin
            w_vec_nxt   = r_vec + VEC_W'(1);
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = VEC_ENTRY;
          end
        end
      end

      DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_vec_out  = r_vec;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_tt_out   = r_tt;
  assign o_ones_cnt = r_ones;

endmodule

// File: tb/tb_function_sweep_ctrl.sv
// ============================================================================
// tb_function_sweep_ctrl
// ----------------------------------------------------------------------------
// Directed and randomized sweeps of function_sweep_ctrl. Two instances are
// used: dut1 with SETTLE_CYC=1 and dut0 with SETTLE_CYC=0. The datapath function
// f is a lookup table indexed by the vector. Expected maps, counts and
// latencies are derived from the sweep range and that table.
// ============================================================================
module tb_function_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start0;
  logic [4:0]  first, last;
  logic        abort1;
  logic [31:0] tbl;

  logic [4:0]  vec1, vec0;
  logic        busy1, busy0, done1, done0, err1, err0;
  logic [31:0] tt1, tt0;
  logic [5:0]  ones1, ones0;
  logic        f1, f0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] exp_tt1;
  logic [5:0]  exp_ones1;
  logic [4:0]  exp_vec1;

  always #5 clk = ~clk;

  assign f1 = tbl[vec1];
  assign f0 = tbl[vec0];

  function_sweep_ctrl #(.VEC_W(5), .SETTLE_CYC(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1),
    .i_first_vec(first), .i_last_vec(last),
`ifdef FUNC_SWEEP_ABORT_EN
    .i_abort(abort1),
`endif
    .i_f_in(f1), .o_vec_out(vec1), .o_busy(busy1), .o_done(done1),
    .o_err(err1), .o_tt_out(tt1), .o_ones_cnt(ones1)
  );

  function_sweep_ctrl #(.VEC_W(5), .SETTLE_CYC(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0),
    .i_first_vec(first), .i_last_vec(last),
`ifdef FUNC_SWEEP_ABORT_EN
    .i_abort(1'b0),
`endif
    .i_f_in(f0), .o_vec_out(vec0), .o_busy(busy0), .o_done(done0),
    .o_err(err0), .o_tt_out(tt0), .o_ones_cnt(ones0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result of a sweep, computed from the range and f table.
  task automatic model(input logic [4:0] f, input logic [4:0] l,
                       output logic [31:0] ett, output logic [5:0] eones);
    ett = '0;
    eones = '0;
    for (int k = int'(f); k <= int'(l); k++) begin
      if (tbl[k]) begin
        ett[k] = 1'b1;
        eones  = eones + 6'd1;
      end
    end
  endtask

  // Runs one accepted sweep on dut0 (s0=1) or dut1. It can optionally pulse
  // start mid-sweep and in the DONE-state cycle (the cycle before done).
  task automatic sweep(input bit s0, input logic [4:0] f, input logic [4:0] l,
                       input bit inject, input string tag);
    int unsigned n, lat, cyc;
    logic [31:0] ett;
    logic [5:0]  eones;
    bit busy_ok, seen;
    n   = int'(l) - int'(f) + 1;
    lat = n * ((s0 ? 0 : 1) + 1) + 1;
    model(f, l, ett, eones);
    @(negedge clk);
    first = f; last = l;
    if (s0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cyc = 0; busy_ok = 1'b1; seen = 1'b0;
    while (!seen && cyc < lat + 20) begin
      if (s0 ? done0 : done1) begin
        seen = 1'b1;
      end else begin
        if ((s0 ? busy0 : busy1) !== 1'b1) busy_ok = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        if (inject && (cyc == 2 || cyc == lat - 1)) begin
          first = 5'd0; last = 5'd31;
          if (s0) start0 = 1'b1; else start1 = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
      end
    end
    start0 = 1'b0; start1 = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"},   64'(cyc),  64'(lat));
    chk({tag, "_busy_run"},  64'(busy_ok), 64'd1);
    chk({tag, "_busy_done"}, 64'(s0 ? busy0 : busy1), 64'd0);
    chk({tag, "_tt"},        64'(s0 ? tt0 : tt1),     64'(ett));
    chk({tag, "_ones"},      64'(s0 ? ones0 : ones1), 64'(eones));
    chk({tag, "_vec"},       64'(s0 ? vec0 : vec1),   64'(l));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(s0 ? done0 : done1), 64'd0);
    chk({tag, "_idle_after"}, 64'(s0 ? busy0 : busy1), 64'd0);
    if (!s0) begin
      exp_tt1 = ett; exp_ones1 = eones; exp_vec1 = l;
    end
  endtask

  // Rejected range on dut1: err pulse only, nothing else moves.
  task automatic reject(input logic [4:0] f, input logic [4:0] l, input string tag);
    bit quiet;
    @(negedge clk);
    first = f; last = l; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    chk({tag, "_err"},  64'(err1),  64'd1);
    chk({tag, "_busy"}, 64'(busy1), 64'd0);
    chk({tag, "_tt"},   64'(tt1),   64'(exp_tt1));
    chk({tag, "_ones"}, 64'(ones1), 64'(exp_ones1));
    chk({tag, "_vec"},  64'(vec1),  64'(exp_vec1));
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (err1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) quiet = 1'b0;
    end
    chk({tag, "_quiet"}, 64'(quiet), 64'd1);
  endtask

  initial begin
    bit quiet;
    logic [4:0] a, b;
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; abort1 = 1'b0;
    first = '0; last = '0; tbl = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vec1",  64'(vec1),  64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_done1", 64'(done1), 64'd0);
    chk("rst_err1",  64'(err1),  64'd0);
    chk("rst_tt1",   64'(tt1),   64'd0);
    chk("rst_ones1", 64'(ones1), 64'd0);
    chk("rst_busy0", 64'(busy0), 64'd0);
    chk("rst_tt0",   64'(tt0),   64'd0);
    rst = 1'b0;
    exp_tt1 = '0; exp_ones1 = '0; exp_vec1 = '0;

    // Reset held for two cycles in the middle of a sweep.
    tbl = '1;
    @(negedge clk);
    first = 5'd0; last = 5'd31; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_vec",  64'(vec1),  64'd0);
    chk("mid_rst_busy", 64'(busy1), 64'd0);
    chk("mid_rst_done", 64'(done1), 64'd0);
    chk("mid_rst_err",  64'(err1),  64'd0);
    chk("mid_rst_tt",   64'(tt1),   64'd0);
    chk("mid_rst_ones", 64'(ones1), 64'd0);
    quiet = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0) quiet = 1'b0;
    end
    chk("mid_rst_quiet", 64'(quiet), 64'd1);

    // Parity function over the full range.
    for (int k = 0; k < 32; k++) begin
      logic [4:0] kv;
      kv = k[4:0];
      tbl[k] = ^kv;
    end
    sweep(1'b0, 5'd0, 5'd31, 1'b0, "parity");
    chk("parity_tt_const",   64'(tt1),   64'h9669_6996);
    chk("parity_ones_const", 64'(ones1), 64'd16);

    // f tied high over 2..6.
    tbl = '1;
    sweep(1'b0, 5'd2, 5'd6, 1'b0, "ones26");
    chk("ones26_tt_const", 64'(tt1), 64'h0000_007C);

    reject(5'd7, 5'd3, "rej73");

    // SETTLE_CYC=0 instance, with start pulses that must be ignored.
    tbl = $urandom;
    sweep(1'b1, 5'd0, 5'd3, 1'b1, "s0_inject");

    // Single-vector sweeps at both ends of the range.
    tbl = $urandom;
    sweep(1'b0, 5'd31, 5'd31, 1'b0, "single31");
    sweep(1'b1, 5'd0, 5'd0, 1'b0, "single0");

    for (int it = 0; it < 6; it++) begin
      tbl = $urandom;
      a = 5'($urandom_range(31, 0));
      b = 5'($urandom_range(31, 0));
      if (a > b) begin
        logic [4:0] t;
        t = a; a = b; b = t;
      end
      sweep(1'b0, a, b, 1'b0, "rand1");
      sweep(1'b1, a, b, (it % 2) == 1, "rand0");
      a = 5'($urandom_range(31, 1));
      b = 5'($urandom_range(int'(a) - 1, 0));
      reject(a, b, "rand_rej");
    end

`ifdef FUNC_SWEEP_ABORT_EN
    begin
      logic [31:0] ett;
      logic [5:0]  eones;
      tbl = $urandom;
      model(5'd0, 5'd3, ett, eones);
      @(negedge clk);
      first = 5'd0; last = 5'd31; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      // Vector 4 is in SETTLE during the cycle after the 8th edge past accept.
      repeat (8) @(negedge clk);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      chk("abort_err",  64'(err1),  64'd1);
      chk("abort_busy", 64'(busy1), 64'd0);
      chk("abort_done", 64'(done1), 64'd0);
      chk("abort_tt",   64'(tt1),   64'(ett));
      chk("abort_ones", 64'(ones1), 64'(eones));
      quiet = 1'b1;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        if (done1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0) quiet = 1'b0;
      end
      chk("abort_quiet", 64'(quiet), 64'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
